// File: rtl/gvp_stream_packer.sv
// Snapshots GVP store events and serializes one framed record per trigger
// into a first-word-fall-through FIFO that feeds a 32-bit AXI4-Stream master.
module gvp_stream_packer #(
    parameter int NUM_SRCS      = 16,
    parameter int FIFO_DEPTH_N2 = 6,
    parameter int MAX_FRAME     = 20
) (
    input  logic                       a_clk,
    input  logic                       a_resetn,
    input  logic [1:0]                 store_data,
    input  logic [31:0]                options,
    input  logic [31:0]                index_data,
    input  logic [47:0]                gvp_time_data,
    input  logic [NUM_SRCS*32-1:0]     srcs_data,
    output logic [31:0]                M_AXIS_tdata,
    output logic                       M_AXIS_tvalid,
    input  logic                       M_AXIS_tready,
    output logic                       M_AXIS_tlast,
    output logic                       stall,
    output logic [FIFO_DEPTH_N2:0]     fifo_level,
    output logic [15:0]                overrun_count,
    output logic [31:0]                frame_count
);

    localparam int LW    = FIFO_DEPTH_N2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_N2;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] STALL_TH   = LW'(DEPTH - MAX_FRAME);
    localparam logic [15:0]   SRC_VALID  = 16'((33'd1 << NUM_SRCS) - 33'd1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               store_q;
    logic [31:0]              index_q;
    logic [1:0]               typ;
    logic [15:0]              snap_mask;
    logic [15:0]              rem_mask;
    logic [31:0]              snap_index;
    logic [47:0]              snap_time;
    logic [NUM_SRCS*32-1:0]   snap_srcs;
    logic [2:0]               ptr;

    logic                     trigger;
    logic [2:0]               hdr_len;
    logic                     in_hdr;
    logic [3:0]               src_sel;
    logic [15:0]              rem_next;
    logic [31:0]              word;
    logic [31:0]              src_word;
    logic                     last_word;
    logic                     fifo_wr;
    logic                     fifo_pop;
    logic                     full;

    logic [32:0]              mem [DEPTH];
    logic [FIFO_DEPTH_N2-1:0] wr_addr, rd_addr;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) lowest_set = 4'(i);
        end
    endfunction

    assign trigger  = (store_data != 2'd0) &&
                      ((store_data != store_q) || (index_data != index_q));
    assign hdr_len  = (typ == 2'd1) ? 3'd1 : 3'd4;
    assign in_hdr   = (ptr < hdr_len);
    assign src_sel  = lowest_set(rem_mask);
    // rem_mask holds the sources still to be sent; clearing its lowest bit walks them in ascending order
    assign rem_next = rem_mask & (rem_mask - 16'd1);

    always_comb begin
        src_word = '0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            if (src_sel == 4'(k)) src_word = snap_srcs[k*32 +: 32];
        end
    end

    always_comb begin
        word      = src_word;
        last_word = (rem_next == 16'd0);
        if (in_hdr) begin
            last_word = (ptr == hdr_len - 3'd1) && (rem_mask == 16'd0);
            case (ptr)
                3'd0:    word = (typ == 2'd3) ? 32'hF000_FFFF : {2'b00, typ, 12'h000, snap_mask};
                3'd1:    word = snap_index;
                3'd2:    word = snap_time[31:0];
                default: word = {16'h0000, snap_time[47:32]};
            endcase
        end
    end

    assign full     = (fifo_level == LEVEL_FULL);
    assign fifo_wr  = (state == EMIT) && !full;
    assign fifo_pop = M_AXIS_tvalid && M_AXIS_tready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = EMIT;
            EMIT:    if (fifo_wr && last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state         <= IDLE;
            store_q       <= '0;
            index_q       <= '0;
            typ           <= '0;
            snap_mask     <= '0;
            rem_mask      <= '0;
            snap_index    <= '0;
            snap_time     <= '0;
            snap_srcs     <= '0;
            ptr           <= '0;
            overrun_count <= '0;
            frame_count   <= '0;
        end else begin
            state   <= state_nxt;
            store_q <= store_data;
            index_q <= index_data;
            if ((state == IDLE) && trigger) begin
                typ        <= store_data;
                snap_mask  <= (store_data == 2'd3) ? 16'h0000 : options[15:0];
                rem_mask   <= (store_data == 2'd3) ? 16'h0000 : (options[15:0] & SRC_VALID);
                snap_index <= index_data;
                snap_time  <= gvp_time_data;
                snap_srcs  <= srcs_data;
                ptr        <= '0;
            end else if (fifo_wr) begin
                if (in_hdr) ptr <= ptr + 3'd1;
                else        rem_mask <= rem_next;
                if (last_word) frame_count <= frame_count + 32'd1;
            end
            // A trigger arriving mid-frame is counted and dropped; the frame in flight is untouched
            if ((state == EMIT) && trigger && (overrun_count != 16'hFFFF))
                overrun_count <= overrun_count + 16'd1;
        end
    end

    always_ff @(posedge a_clk) begin
        if (fifo_wr) mem[wr_addr] <= {last_word, word};
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            fifo_level <= '0;
            stall      <= 1'b0;
        end else begin
            if (fifo_wr)  wr_addr <= wr_addr + 1'b1;
            if (fifo_pop) rd_addr <= rd_addr + 1'b1;
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            stall <= (fifo_level > STALL_TH);
        end
    end

    // Fall-through read: the head word is presented as soon as it lands
    assign M_AXIS_tvalid = (fifo_level != '0);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? mem[rd_addr][31:0] : 32'h0;
    assign M_AXIS_tlast  = M_AXIS_tvalid ? mem[rd_addr][32] : 1'b0;

endmodule

// File: doc/gvp_stream_packer.md
Name: gvp_stream_packer

Overview:
- Consumer stage directly downstream of the General Vector Program core.
- Watches the store trigger, snapshots index, time, options mask and up to 16 source channels, then serializes one framed record per trigger into an output FIFO.
- Drives a 32-bit AXI4-Stream master toward the AXI DMA.
- Asserts stall back to the GVP core when the FIFO cannot absorb a worst-case frame.

Parameters:
NUM_SRCS, 16, number of 32-bit source channels on srcs_data (1..16)
FIFO_DEPTH_N2, 6, log2 of output FIFO depth in words (default 64)
MAX_FRAME, 20, worst-case frame length in words (4 + NUM_SRCS); sets the stall threshold

Ports:
a_clk  in  1  clock
a_resetn  in  1  asynchronous active-low reset
store_data  in  2  GVP store trigger: 0 none, 1 data point, 2 section header, 3 end of program
options  in  32  GVP section options; bits [15:0] are the source select mask
index_data  in  32  GVP point index
gvp_time_data  in  48  GVP time counter
srcs_data  in  NUM_SRCS*32  source channels, channel k at [k*32+31:k*32]
M_AXIS_tdata  out  32  packed stream word
M_AXIS_tvalid  out  1  word valid
M_AXIS_tready  in  1  DMA accept
M_AXIS_tlast  out  1  last word of frame
stall  out  1  to GVP stall input; FIFO near full
fifo_level  out  FIFO_DEPTH_N2+1  words currently in FIFO
overrun_count  out  16  triggers dropped, saturating
frame_count  out  32  frames fully written to FIFO, wrapping

Behaviour:
- Reset (a_resetn low, async): FIFO empty, FSM IDLE, all snapshot, store_q, index_q and counters at 0.
  - Outputs while in reset: tvalid=0, tlast=0, tdata=0, stall=0, fifo_level=0.
  - Reset mid-frame discards the partial frame; no tlast is emitted for it.
- Trigger condition, evaluated each a_clk: store_data!=0 AND (store_data!=store_q OR index_data!=index_q).
  - store_q and index_q register store_data and index_data every cycle.
  - A held store value (decimation, or finished state held at 3) yields exactly one frame.
- FSM states: IDLE, EMIT.
  - IDLE: on trigger edge E0, snapshot type=store_data, mask=options[15:0] (forced to 0 for type 3), index, time and all sources. Go to EMIT with word pointer 0.
  - EMIT: write one word per cycle while FIFO not full; hold pointer when full. On the last word, set its tlast bit, increment frame_count, return to IDLE.
- Frame formats (sources in ascending channel order, only mask bits set and < NUM_SRCS):
  - Type 1: W0={4'h1,12'h000,mask}, then sources.
  - Type 2: W0={4'h2,12'h000,mask}, W1=index, W2=time[31:0], W3={16'h0,time[47:32]}, then sources.
  - Type 3: W0=32'hF000FFFF, W1=index, W2=time[31:0], W3={16'h0,time[47:32]}; no sources.
- Latency: first word written at E1 and visible on M_AXIS (tvalid=1) in the cycle after E1. FIFO is fall-through (first-word-fall-through).
- Minimum frame duration is N words = N cycles in EMIT when there is no backpressure.
- Trigger while in EMIT: the trigger is dropped, overrun_count increments (saturates at 16'hFFFF), and the current frame completes intact.
- AXIS: a word pops on tvalid&&tready. tdata and tlast stay stable while tvalid&&!tready. tlast is stored per word as a 33rd FIFO bit.
- Simultaneous FIFO write and pop: level unchanged. Write when full: blocked; no overwrite.
- stall is registered: stall=1 when fifo_level > 2^FIFO_DEPTH_N2 - MAX_FRAME (default level > 44), else 0.
- Width rules: fifo_level counts 0..2^FIFO_DEPTH_N2 inclusive. frame_count wraps modulo 2^32.

Test Plan:
- Header frame: store_data 0→2, index=7, time=0x0001_0000_0010, mask=0x0005, src0=0xA, src2=0xC, tready=1 → words 0x20000005, 7, 0x00000010, 0x00000001, 0xA, 0xC. tlast only on 0xC; frame_count=1.
- Data frames: store_data held 1 while index steps 5→4→3, mask=0 → three single words 0x10000000, each with tlast=1.
- End: store_data held 3 for 100 cycles, options=0xFFFFFFFF → exactly one 4-word frame starting 0xF000FFFF; no source words.
- Backpressure: tready=0, repeated type-2 frames with mask=0xFFFF (20 words each) → stall rises the cycle after level exceeds 44, writes block at level 64, and no word is lost or reordered after tready=1.
- Overrun: second trigger 3 cycles into a 20-word frame → overrun_count=1, first frame complete with tlast, second frame absent.
- Reset: a_resetn low mid-EMIT → tvalid=0 and fifo_level=0 immediately. After release, the next trigger produces a clean frame.
